issue: RTL and testbench

ISSUE -- requirements
Module: issue

---
 rtl/issue_pkg.sv | 56 +++++
 rtl/issue_rs.sv | 100 ++++++++++
 rtl/issue.sv | 63 ++++++
 tb/tb_issue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and sizing for the issue stage: dispatch, CDB and issue packets
// plus small bit-vector helpers used by the reservation station.
package issue_pkg;

  localparam int RS_SIZE = 8;
  localparam int TAG_W   = 6;
  localparam int BMASK_W = 4;

  typedef logic [BMASK_W-1:0] BRANCH_MASK;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] T;
    logic             T_used;
    logic [TAG_W-1:0] T1;
    logic             T1r;
    logic             T1_used;
    logic [TAG_W-1:0] T2;
    logic             T2r;
    logic             T2_used;
    BRANCH_MASK       branch_tag;
    logic             is_load;
    logic             is_store;
    logic [63:0]      payload;
  } DISPATCH_PACKET;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] T;
  } CDB_PACKET;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] T;
    logic             T_used;
    logic [TAG_W-1:0] T1;
    logic             T1_used;
    logic [TAG_W-1:0] T2;
    logic             T2_used;
    BRANCH_MASK       branch_tag;
    logic             is_load;
    logic             is_store;
    logic [63:0]      payload;
  } IS_PACKET;

  // An operand the instruction does not read never holds it back.
  function automatic logic op_ready(input logic used, input logic rdy);
    return ~used | rdy;
  endfunction

  // Isolate the lowest set bit: v & -v.
  function automatic logic [RS_SIZE-1:0] lowest_one(input logic [RS_SIZE-1:0] v);
    return v & (~v + {{(RS_SIZE-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/issue_rs.sv
// Reservation-station entry array with CDB wakeup and lowest-index select;
// eligibility (LQ/SQ/branch) and squash kills come from the enclosing stage.
module issue_rs
  import issue_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write_en,
  input  DISPATCH_PACKET             dispatch_in,
  input  CDB_PACKET                  cdb_in,
  input  logic [RS_SIZE-1:0]         kill_vec,
  input  logic [RS_SIZE-1:0]         eligible_vec,
  output logic [RS_SIZE-1:0]         valid_vec,
  output logic [RS_SIZE-1:0]         load_vec,
  output logic [RS_SIZE-1:0]         store_vec,
  output BRANCH_MASK [RS_SIZE-1:0]   btag_vec,
  output IS_PACKET                   issue_pkt
);

  DISPATCH_PACKET [RS_SIZE-1:0] entries_r;
  DISPATCH_PACKET               new_entry_s;
  IS_PACKET                     is_row_s;
  logic [RS_SIZE-1:0]           cand_s;
  logic [RS_SIZE-1:0]           issue_sel_s;
  logic [RS_SIZE-1:0]           write_sel_s;

  // Per-entry status vectors and the one-hot issue / write slot picks.
  always_comb begin
    valid_vec = '0;
    load_vec  = '0;
    store_vec = '0;
    btag_vec  = '0;
    cand_s    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      valid_vec[i] = entries_r[i].valid;
      load_vec[i]  = entries_r[i].is_load;
      store_vec[i] = entries_r[i].is_store;
      btag_vec[i]  = entries_r[i].branch_tag;
      cand_s[i]    = entries_r[i].valid & eligible_vec[i]
                   & op_ready(entries_r[i].T1_used, entries_r[i].T1r)
                   & op_ready(entries_r[i].T2_used, entries_r[i].T2r);
    end
    issue_sel_s = lowest_one(cand_s);
    // A slot vacated by this cycle's issue may be refilled at the same edge.
    write_sel_s = lowest_one(~valid_vec | issue_sel_s) & {RS_SIZE{write_en}};
  end

  // One-hot OR-mux of the selected entry onto the issue packet.
  always_comb begin
    issue_pkt = '0;
    is_row_s  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      is_row_s = '{valid:      entries_r[i].valid,
                   T:          entries_r[i].T,
                   T_used:     entries_r[i].T_used,
                   T1:         entries_r[i].T1,
                   T1_used:    entries_r[i].T1_used,
                   T2:         entries_r[i].T2,
                   T2_used:    entries_r[i].T2_used,
                   branch_tag: entries_r[i].branch_tag,
                   is_load:    entries_r[i].is_load,
                   is_store:   entries_r[i].is_store,
                   payload:    entries_r[i].payload};
      issue_pkt = issue_pkt | (is_row_s & {$bits(IS_PACKET){issue_sel_s[i]}});
    end
  end

  // Incoming entry catches a tag broadcast in the same cycle it is written.
  always_comb begin
    new_entry_s       = dispatch_in;
    new_entry_s.valid = 1'b1;
    new_entry_s.T1r   = dispatch_in.T1r | (cdb_in.valid & (dispatch_in.T1 == cdb_in.T));
    new_entry_s.T2r   = dispatch_in.T2r | (cdb_in.valid & (dispatch_in.T2 == cdb_in.T));
  end

  // Entry update priority: squash, then dispatch write, then issue-free, then wakeup.
  always_ff @(posedge clock) begin
    if (!reset) begin
      entries_r <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (kill_vec[i]) begin
          entries_r[i].valid <= 1'b0;
        end else if (write_sel_s[i]) begin
          entries_r[i] <= new_entry_s;
        end else if (issue_sel_s[i]) begin
          entries_r[i].valid <= 1'b0;
        end else if (entries_r[i].valid) begin
          entries_r[i].T1r <= entries_r[i].T1r | (cdb_in.valid & entries_r[i].T1_used
                                                  & (entries_r[i].T1 == cdb_in.T));
          entries_r[i].T2r <= entries_r[i].T2r | (cdb_in.valid & entries_r[i].T2_used
                                                  & (entries_r[i].T2 == cdb_in.T));
        end else begin
          entries_r[i] <= entries_r[i];
        end
      end
    end
  end

endmodule

// File: rtl/issue.sv
// Issue stage: wraps the reservation station with load/store-queue gating,
// branch-squash handling and the full / available handshake.
module issue
  import issue_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  DISPATCH_PACKET dispatch_in,
  input  CDB_PACKET      cdb_in,
  input  BRANCH_MASK     branch_tag_in,
  input  logic           lq_full,
  input  logic           sq_full,
  output IS_PACKET       issue_out,
  output logic           rs_full,
  output logic           rs_available
);

  logic [RS_SIZE-1:0]       valid_vec_s;
  logic [RS_SIZE-1:0]       load_vec_s;
  logic [RS_SIZE-1:0]       store_vec_s;
  BRANCH_MASK [RS_SIZE-1:0] btag_vec_s;
  logic [RS_SIZE-1:0]       kill_vec_s;
  logic [RS_SIZE-1:0]       eligible_vec_s;
  logic                     write_en_s;
  IS_PACKET                 rs_issue_s;

  issue_rs u_rs (
    .clock        (clock),
    .reset        (reset),
    .write_en     (write_en_s),
    .dispatch_in  (dispatch_in),
    .cdb_in       (cdb_in),
    .kill_vec     (kill_vec_s),
    .eligible_vec (eligible_vec_s),
    .valid_vec    (valid_vec_s),
    .load_vec     (load_vec_s),
    .store_vec    (store_vec_s),
    .btag_vec     (btag_vec_s),
    .issue_pkt    (rs_issue_s)
  );

  // Squashed entries are killed and can never be the one selected this cycle.
  always_comb begin
    kill_vec_s     = '0;
    eligible_vec_s = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      kill_vec_s[i]     = valid_vec_s[i] & (|(btag_vec_s[i] & branch_tag_in));
      eligible_vec_s[i] = ~(|(btag_vec_s[i] & branch_tag_in))
                        & ~(load_vec_s[i] & lq_full)
                        & ~(store_vec_s[i] & sq_full);
    end
  end

  // Handshake and outputs, all derived from registered entry state.
  always_comb begin
    rs_full      = &valid_vec_s;
    rs_available = ~rs_full | rs_issue_s.valid;
    write_en_s   = dispatch_in.valid & rs_available
                 & ~(|(dispatch_in.branch_tag & branch_tag_in));
    issue_out    = rs_issue_s;
  end

endmodule

// File: tb/tb_issue.sv
// Randomized + directed bench for the issue stage against a slot-array model.
module tb_issue;
  import issue_pkg::*;

  logic           clock;
  logic           reset;
  DISPATCH_PACKET dispatch_in;
  CDB_PACKET      cdb_in;
  BRANCH_MASK     branch_tag_in;
  logic           lq_full;
  logic           sq_full;
  IS_PACKET       issue_out;
  logic           rs_full;
  logic           rs_available;

  issue dut (
    .clock         (clock),
    .reset         (reset),
    .dispatch_in   (dispatch_in),
    .cdb_in        (cdb_in),
    .branch_tag_in (branch_tag_in),
    .lq_full       (lq_full),
    .sq_full       (sq_full),
    .issue_out     (issue_out),
    .rs_full       (rs_full),
    .rs_available  (rs_available)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  DISPATCH_PACKET m [RS_SIZE];
  logic           obs_valid;
  logic [TAG_W-1:0] obs_T;
  logic           obs_full;
  logic           obs_avail;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic bit can_issue(int i, logic lq, logic sq, BRANCH_MASK b);
    DISPATCH_PACKET e;
    e = m[i];
    return e.valid && (!e.T1_used || e.T1r) && (!e.T2_used || e.T2r)
        && !(e.is_load && lq) && !(e.is_store && sq) && ((e.branch_tag & b) == 4'b0000);
  endfunction

  function automatic DISPATCH_PACKET mk(int t, int t1, logic r1, int t2, logic r2,
                                       BRANCH_MASK bt, logic ld, logic st);
    DISPATCH_PACKET d;
    d = '0;
    d.valid = 1'b1;
    d.T = 6'(t);   d.T_used = 1'b1;
    d.T1 = 6'(t1); d.T1r = r1; d.T1_used = 1'b1;
    d.T2 = 6'(t2); d.T2r = r2; d.T2_used = 1'b1;
    d.branch_tag = bt; d.is_load = ld; d.is_store = st;
    d.payload = {32'hC0DE0000 | 32'(t), 32'(t1 * 7 + t2)};
    return d;
  endfunction

  function automatic CDB_PACKET cdb(logic v, int t);
    CDB_PACKET c;
    c.valid = v;
    c.T = 6'(t);
    return c;
  endfunction

  // Drive one cycle, compare against the model, then advance the model past the edge.
  task automatic step(input DISPATCH_PACKET d, input CDB_PACKET c, input BRANCH_MASK b,
                      input logic lq, input logic sq, input logic rst_n);
    IS_PACKET exp_is;
    int sel, cnt, slot;
    logic exp_full, exp_avail, acc;
    @(negedge clock);
    dispatch_in = d; cdb_in = c; branch_tag_in = b;
    lq_full = lq; sq_full = sq; reset = rst_n;
    #1;
    sel = -1; cnt = 0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (m[i].valid) cnt++;
      if (sel < 0 && can_issue(i, lq, sq, b)) sel = i;
    end
    exp_full  = (cnt == RS_SIZE);
    exp_avail = !exp_full || (sel >= 0);
    exp_is = '0;
    if (sel >= 0) begin
      exp_is.valid = 1'b1;
      exp_is.T = m[sel].T;   exp_is.T_used = m[sel].T_used;
      exp_is.T1 = m[sel].T1; exp_is.T1_used = m[sel].T1_used;
      exp_is.T2 = m[sel].T2; exp_is.T2_used = m[sel].T2_used;
      exp_is.branch_tag = m[sel].branch_tag;
      exp_is.is_load = m[sel].is_load; exp_is.is_store = m[sel].is_store;
      exp_is.payload = m[sel].payload;
    end
    check("issue_out", 128'(issue_out), 128'(exp_is));
    check("rs_full", 128'(rs_full), 128'(exp_full));
    check("rs_available", 128'(rs_available), 128'(exp_avail));
    obs_valid = issue_out.valid; obs_T = issue_out.T;
    obs_full = rs_full; obs_avail = rs_available;

    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) m[i] = '0;
    end else begin
      acc = d.valid && exp_avail && ((d.branch_tag & b) == 4'b0000);
      slot = -1;
      for (int i = 0; i < RS_SIZE; i++)
        if (slot < 0 && (!m[i].valid || i == sel)) slot = i;
      for (int i = 0; i < RS_SIZE; i++)
        if (m[i].valid && ((m[i].branch_tag & b) != 4'b0000)) m[i].valid = 1'b0;
      if (sel >= 0) m[sel].valid = 1'b0;
      if (c.valid) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (m[i].valid && m[i].T1_used && m[i].T1 == c.T) m[i].T1r = 1'b1;
          if (m[i].valid && m[i].T2_used && m[i].T2 == c.T) m[i].T2r = 1'b1;
        end
      end
      if (acc) begin
        m[slot] = d;
        if (c.valid && d.T1 == c.T) m[slot].T1r = 1'b1;
        if (c.valid && d.T2 == c.T) m[slot].T2r = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step('0, '0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic DISPATCH_PACKET rand_disp();
    DISPATCH_PACKET d;
    BRANCH_MASK bm;
    d = '0;
    d.valid   = ($urandom_range(0, 3) != 0);
    d.T       = 6'($urandom_range(0, 63));
    d.T_used  = ($urandom_range(0, 1) == 1);
    d.T1      = 6'($urandom_range(0, 7));
    d.T1r     = ($urandom_range(0, 3) == 0);
    d.T1_used = ($urandom_range(0, 4) != 0);
    d.T2      = 6'($urandom_range(0, 7));
    d.T2r     = ($urandom_range(0, 3) == 0);
    d.T2_used = ($urandom_range(0, 4) != 0);
    bm = 4'b0001 << $urandom_range(0, 3);
    d.branch_tag = ($urandom_range(0, 2) == 0) ? bm : 4'b0000;
    d.is_load  = ($urandom_range(0, 3) == 0);
    d.is_store = !d.is_load && ($urandom_range(0, 3) == 0);
    d.payload  = {$urandom, $urandom};
    return d;
  endfunction

  initial begin
    BRANCH_MASK bm;
    for (int i = 0; i < RS_SIZE; i++) m[i] = '0;
    reset = 1'b0; dispatch_in = '0; cdb_in = '0; branch_tag_in = 4'b0000;
    lq_full = 1'b0; sq_full = 1'b0;

    // Reset then idle
    do_reset(); do_reset();
    idle(1);
    check("rst_full", 128'(obs_full), 128'(1'b0));
    check("rst_avail", 128'(obs_avail), 128'(1'b1));
    check("rst_valid", 128'(obs_valid), 128'(1'b0));

    // Ready dispatch issues on the next cycle and frees its slot
    step(mk(0, 0, 1'b1, 0, 1'b1, 4'b0000, 1'b0, 1'b0), '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("lat1_valid", 128'(obs_valid), 128'(1'b1));
    check("lat1_T", 128'(obs_T), 128'(6'd0));
    idle(1);
    check("lat1_freed", 128'(obs_valid), 128'(1'b0));

    // Fill the station, drop overflow, then wake T=3 and refill its slot
    for (int i = 0; i < RS_SIZE; i++)
      step(mk(i, i, i == 0, i, i == 0, 4'b0000, 1'b0, 1'b0), '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(mk(8, 8, 1'b0, 8, 1'b0, 4'b0000, 1'b0, 1'b0), '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("fill_full", 128'(obs_full), 128'(1'b1));
    check("fill_avail", 128'(obs_avail), 128'(1'b0));
    step(mk(9, 9, 1'b0, 9, 1'b0, 4'b0000, 1'b0, 1'b0), '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step('0, cdb(1'b1, 3), 4'b0000, 1'b0, 1'b0, 1'b1);
    check("wake_full_before", 128'(obs_full), 128'(1'b1));
    step(mk(10, 10, 1'b0, 10, 1'b0, 4'b0000, 1'b0, 1'b0), '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("wake_valid", 128'(obs_valid), 128'(1'b1));
    check("wake_T", 128'(obs_T), 128'(6'd3));
    check("wake_avail", 128'(obs_avail), 128'(1'b1));
    idle(1);
    check("refill_full", 128'(obs_full), 128'(1'b1));

    // Load held while the load queue is full
    do_reset();
    step(mk(5, 1, 1'b1, 2, 1'b1, 4'b0000, 1'b1, 1'b0), '0, 4'b0000, 1'b1, 1'b0, 1'b1);
    step('0, '0, 4'b0000, 1'b1, 1'b0, 1'b1);
    check("lq_block", 128'(obs_valid), 128'(1'b0));
    step('0, '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("lq_release", 128'(obs_valid), 128'(1'b1));
    check("lq_release_T", 128'(obs_T), 128'(6'd5));

    // Squash removes only the matching branch entry
    do_reset();
    step(mk(11, 20, 1'b0, 20, 1'b0, 4'b0010, 1'b0, 1'b0), '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(mk(12, 21, 1'b0, 21, 1'b0, 4'b0001, 1'b0, 1'b0), '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step('0, '0, 4'b0010, 1'b0, 1'b0, 1'b1);
    step('0, cdb(1'b1, 20), 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("squash_gone", 128'(obs_valid), 128'(1'b0));
    step('0, cdb(1'b1, 21), 4'b0000, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("squash_keep", 128'(obs_valid), 128'(1'b1));
    check("squash_keep_T", 128'(obs_T), 128'(6'd12));

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      bm = 4'b0001 << $urandom_range(0, 3);
      step(rand_disp(),
           cdb(($urandom_range(0, 1) == 1), $urandom_range(0, 7)),
           ($urandom_range(0, 15) == 0) ? bm : 4'b0000,
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
